// File: rtl/uart_rx_ctrl.sv
// Receive-side controller for the oversampling UART receiver: arms it, holds the frame config,
// and queues received bytes with error tags. Optional frame timeout under UART_RX_CTRL_TIMEOUT_EN.
module uart_rx_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 cfg_wr,
    input  logic [3:0]           cfg_length,
    input  logic                 cfg_parity_en,
    input  logic                 cfg_parity_type,
    input  logic                 cfg_stop2,
    output logic                 cfg_err,
    input  logic                 rx_line,
    output logic                 rx_start,
    output logic [3:0]           rx_length,
    output logic                 rx_parity_en,
    output logic                 rx_parity_type,
    output logic                 rx_stop2,
    input  logic [7:0]           rx_data,
    input  logic                 rx_done,
    input  logic                 rx_error,
    output logic [7:0]           m_data,
    output logic                 m_err,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 overrun,
    output logic [ERR_CNT_W-1:0] err_count,
    input  logic                 err_clr,
    output logic                 busy,
    output logic                 timeout
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_ARMED = 2'd1,
        ST_FRAME = 2'd2
    } state_t;

    function automatic logic len_legal(input logic [3:0] len);
        return (len >= 4'd5) && (len <= 4'd8);
    endfunction

    state_t               state_r, state_nxt_s;
    logic                 frame_err_r;
    logic                 rx_start_r, busy_r, cfg_err_r, timeout_r, overrun_r;
    logic [ERR_CNT_W-1:0] err_cnt_r;
    logic [3:0]           len_r, pend_len_r;
    logic                 pe_r, pt_r, s2_r, pend_pe_r, pend_pt_r, pend_s2_r, pend_valid_r;
    logic [8:0]           mem_r [FIFO_DEPTH];
    logic [AW:0]          wr_ptr_r, rd_ptr_r;

    logic cap_s, tag_s, full_s, empty_s, pop_s, push_s, drop_s, err_inc_s;
    logic cfg_ok_s, leave_frame_s, timeout_hit_s;

`ifdef UART_RX_CTRL_TIMEOUT_EN
    logic [8:0] frame_cnt_r;
    logic [4:0] limit_units_s;
    logic [8:0] limit_s;

    assign limit_units_s = 5'd3 + {1'b0, len_r} + {4'd0, pe_r} + {4'd0, s2_r};
    assign limit_s       = {limit_units_s, 4'd0};
    assign timeout_hit_s = (state_r == ST_FRAME) && !rx_done && (frame_cnt_r == (limit_s - 9'd1));

    // Frame-length counter: zero on FRAME entry, counts every FRAME cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_r <= 9'd0;
        end else if ((state_r != ST_FRAME) && (state_nxt_s == ST_FRAME)) begin
            frame_cnt_r <= 9'd0;
        end else if (state_r == ST_FRAME) begin
            frame_cnt_r <= frame_cnt_r + 9'd1;
        end
    end
`else
    assign timeout_hit_s = 1'b0;
`endif

    assign cap_s         = rx_done && (state_r != ST_OFF);
    // Error flag only belongs to the frame in flight; a done seen in ARMED carries only rx_error
    assign tag_s         = ((state_r == ST_FRAME) && frame_err_r) || rx_error;
    assign empty_s       = (wr_ptr_r == rd_ptr_r);
    assign full_s        = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign pop_s         = !empty_s && m_ready;
    assign push_s        = cap_s && (!full_s || pop_s);
    assign drop_s        = cap_s && !push_s;
    assign err_inc_s     = (cap_s && (tag_s || drop_s)) || timeout_hit_s;
    assign cfg_ok_s      = cfg_wr && len_legal(cfg_length);
    assign leave_frame_s = (state_r == ST_FRAME) && (rx_done || timeout_hit_s);

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_OFF: begin
                if (enable) state_nxt_s = ST_ARMED;
                else        state_nxt_s = ST_OFF;
            end
            ST_ARMED: begin
                if (rx_done)       state_nxt_s = enable ? ST_ARMED : ST_OFF;
                else if (!enable)  state_nxt_s = ST_OFF;
                else if (!rx_line) state_nxt_s = ST_FRAME;
                else               state_nxt_s = ST_ARMED;
            end
            ST_FRAME: begin
                if (rx_done || timeout_hit_s) state_nxt_s = enable ? ST_ARMED : ST_OFF;
                else                          state_nxt_s = ST_FRAME;
            end
            default: state_nxt_s = ST_OFF;
        endcase
    end

    // State register, registered status outputs and frame error accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_OFF;
            rx_start_r  <= 1'b0;
            busy_r      <= 1'b0;
            cfg_err_r   <= 1'b0;
            timeout_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            rx_start_r <= (state_nxt_s != ST_OFF);
            busy_r     <= (state_nxt_s == ST_FRAME);
            cfg_err_r  <= cfg_wr && !len_legal(cfg_length);
            timeout_r  <= timeout_hit_s;
            if (state_r != ST_FRAME) frame_err_r <= 1'b0;
            else                     frame_err_r <= frame_err_r | rx_error;
        end
    end

    // Active and pending frame configuration; a write arriving on the exit cycle is the newest
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_r        <= 4'd8;
            pe_r         <= 1'b0;
            pt_r         <= 1'b0;
            s2_r         <= 1'b0;
            pend_len_r   <= 4'd8;
            pend_pe_r    <= 1'b0;
            pend_pt_r    <= 1'b0;
            pend_s2_r    <= 1'b0;
            pend_valid_r <= 1'b0;
        end else if (leave_frame_s) begin
            pend_valid_r <= 1'b0;
            if (cfg_ok_s) begin
                len_r <= cfg_length;
                pe_r  <= cfg_parity_en;
                pt_r  <= cfg_parity_type;
                s2_r  <= cfg_stop2;
            end else if (pend_valid_r) begin
                len_r <= pend_len_r;
                pe_r  <= pend_pe_r;
                pt_r  <= pend_pt_r;
                s2_r  <= pend_s2_r;
            end
        end else if (cfg_ok_s) begin
            if (state_r == ST_FRAME) begin
                pend_len_r   <= cfg_length;
                pend_pe_r    <= cfg_parity_en;
                pend_pt_r    <= cfg_parity_type;
                pend_s2_r    <= cfg_stop2;
                pend_valid_r <= 1'b1;
            end else begin
                len_r <= cfg_length;
                pe_r  <= cfg_parity_en;
                pt_r  <= cfg_parity_type;
                s2_r  <= cfg_stop2;
            end
        end
    end

    // Saturating error counter and sticky overrun; a same-cycle event outranks the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_r <= '0;
            overrun_r <= 1'b0;
        end else begin
            if (err_clr)
                err_cnt_r <= err_inc_s ? ERR_CNT_W'(1) : ERR_CNT_W'(0);
            else if (err_inc_s && (err_cnt_r != {ERR_CNT_W{1'b1}}))
                err_cnt_r <= err_cnt_r + ERR_CNT_W'(1);
            if (drop_s)       overrun_r <= 1'b1;
            else if (err_clr) overrun_r <= 1'b0;
        end
    end

    // Receive FIFO storage and pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 9'd0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= {tag_s, rx_data};
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_s) rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
        end
    end

    assign m_valid        = !empty_s;
    assign m_data         = mem_r[rd_ptr_r[AW-1:0]][7:0];
    assign m_err          = mem_r[rd_ptr_r[AW-1:0]][8];
    assign rx_start       = rx_start_r;
    assign busy           = busy_r;
    assign cfg_err        = cfg_err_r;
    assign timeout        = timeout_r;
    assign overrun        = overrun_r;
    assign err_count      = err_cnt_r;
    assign rx_length      = len_r;
    assign rx_parity_en   = pe_r;
    assign rx_parity_type = pt_r;
    assign rx_stop2       = s2_r;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: acts as the receiver, scoreboards FIFO output.
module tb_uart_rx_ctrl;
    localparam int FIFO_DEPTH = 4;
    localparam int ERR_CNT_W  = 8;

    logic                 clk, rst_n, enable, cfg_wr, cfg_parity_en, cfg_parity_type, cfg_stop2;
    logic [3:0]           cfg_length;
    logic                 cfg_err, rx_line, rx_start, rx_parity_en, rx_parity_type, rx_stop2;
    logic [3:0]           rx_length;
    logic [7:0]           rx_data, m_data;
    logic                 rx_done, rx_error, m_err, m_valid, m_ready, overrun, err_clr, busy, timeout;
    logic [ERR_CNT_W-1:0] err_count;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] sb_q[$];
    logic [8:0] sb_exp;

    uart_rx_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .ERR_CNT_W(ERR_CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .cfg_wr(cfg_wr), .cfg_length(cfg_length),
        .cfg_parity_en(cfg_parity_en), .cfg_parity_type(cfg_parity_type), .cfg_stop2(cfg_stop2),
        .cfg_err(cfg_err), .rx_line(rx_line), .rx_start(rx_start), .rx_length(rx_length),
        .rx_parity_en(rx_parity_en), .rx_parity_type(rx_parity_type), .rx_stop2(rx_stop2),
        .rx_data(rx_data), .rx_done(rx_done), .rx_error(rx_error), .m_data(m_data), .m_err(m_err),
        .m_valid(m_valid), .m_ready(m_ready), .overrun(overrun), .err_count(err_count),
        .err_clr(err_clr), .busy(busy), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cfg(input logic [3:0] len, input logic pe, input logic pt, input logic s2);
        cfg_length = len; cfg_parity_en = pe; cfg_parity_type = pt; cfg_stop2 = s2;
        cfg_wr = 1'b1;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic start_frame();
        rx_line = 1'b0;
        tick();
        rx_line = 1'b1;
        check("busy_rise", busy, 1);
    endtask

    task automatic end_frame(input logic [7:0] d, input logic done_err, input logic exp_tag,
                             input logic exp_push);
        rx_data = d; rx_error = done_err; rx_done = 1'b1;
        if (exp_push) sb_q.push_back({exp_tag, d});
        tick();
        rx_done = 1'b0; rx_error = 1'b0;
        check("busy_fall", busy, 0);
    endtask

    task automatic send(input logic [7:0] d, input logic mid_err, input logic done_err,
                        input logic exp_push);
        start_frame();
        for (int i = 0; i < 20; i++) begin
            rx_error = (mid_err && i == 5);
            tick();
        end
        rx_error = 1'b0;
        end_frame(d, done_err, mid_err | done_err, exp_push);
    endtask

    // Scoreboard: every accepted FIFO head must match the oldest expected entry
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected", {m_err, m_data}, 9'h1ff);
            end else begin
                sb_exp = sb_q.pop_front();
                check("sb_head", {m_err, m_data}, sb_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0; enable = 1'b0; cfg_wr = 1'b0; cfg_length = 4'd8; cfg_parity_en = 1'b0;
        cfg_parity_type = 1'b0; cfg_stop2 = 1'b0; rx_line = 1'b1; rx_data = 8'h00;
        rx_done = 1'b0; rx_error = 1'b0; m_ready = 1'b1; err_clr = 1'b0;
        repeat (3) tick();
        check("rst_rx_start", rx_start, 0);
        check("rst_rx_length", rx_length, 8);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_err_count", err_count, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();

        // 8N1 frame
        enable = 1'b1;
        tick();
        check("arm_rx_start", rx_start, 1);
        send(8'hA5, 1'b0, 1'b0, 1'b1);
        check("t1_m_valid", m_valid, 1);
        check("t1_m_data", m_data, 8'hA5);
        check("t1_m_err", m_err, 0);
        check("t1_err_count", err_count, 0);
        tick();

        // 7E1, errored frames, illegal length
        write_cfg(4'd7, 1'b1, 1'b0, 1'b0);
        check("cfg_len7", rx_length, 7);
        check("cfg_pe", rx_parity_en, 1);
        send(8'h3C, 1'b0, 1'b1, 1'b1);
        check("t2_m_err", m_err, 1);
        check("t2_err_count", err_count, 1);
        send(8'h41, 1'b1, 1'b0, 1'b1);
        check("t2_mid_err_count", err_count, 2);
        write_cfg(4'd4, 1'b0, 1'b0, 1'b0);
        check("cfg_err_pulse", cfg_err, 1);
        check("cfg_err_len_kept", rx_length, 7);
        tick();
        check("cfg_err_clear", cfg_err, 0);

        // Overflow: fill with m_ready low, one extra drops
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("clr_err_count", err_count, 0);
        m_ready = 1'b0;
        for (int i = 0; i < FIFO_DEPTH + 1; i++) send(8'h10 + 8'(i), 1'b0, 1'b0, i < FIFO_DEPTH);
        check("ovf_overrun", overrun, 1);
        check("ovf_err_count", err_count, 1);
        check("ovf_head", m_data, 8'h10);
        m_ready = 1'b1;
        repeat (FIFO_DEPTH + 2) tick();
        check("ovf_drained", m_valid, 0);
        check("ovf_sb_empty", sb_q.size(), 0);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("clr_overrun", overrun, 0);
        check("clr_err_count2", err_count, 0);

        write_cfg(4'd8, 1'b0, 1'b0, 1'b0);
`ifdef UART_RX_CTRL_TIMEOUT_EN
        // False start: short glitch must time out after T = 176 cycles
        rx_line = 1'b0;
        tick();
        check("to_busy", busy, 1);
        n = 0;
        while (!timeout && n < 400) begin
            if (n == 3) rx_line = 1'b1;
            tick();
            n++;
        end
        rx_line = 1'b1;
        check("to_cycle", n, 176);
        check("to_err_count", err_count, 1);
        check("to_busy_fall", busy, 0);
        check("to_rx_start", rx_start, 1);
        check("to_m_valid", m_valid, 0);
        tick();
        check("to_pulse", timeout, 0);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
`else
        n = 0;
`endif

        // Mid-frame config is held until the FRAME exit
        start_frame();
        repeat (5) tick();
        cfg_length = 4'd5; cfg_parity_en = 1'b0; cfg_stop2 = 1'b1; cfg_wr = 1'b1;
        tick();
        cfg_wr = 1'b0;
        check("pend_len_hold", rx_length, 8);
        repeat (10) tick();
        check("pend_len_hold2", rx_length, 8);
        check("pend_s2_hold", rx_stop2, 0);
        end_frame(8'h15, 1'b0, 1'b0, 1'b1);
        check("pend_len_apply", rx_length, 5);
        check("pend_s2_apply", rx_stop2, 1);
        send(8'h0B, 1'b0, 1'b0, 1'b1);
        check("len5_err_count", err_count, 0);
        tick();

        // enable drop mid-frame completes the frame then disarms
        start_frame();
        repeat (3) tick();
        enable = 1'b0;
        repeat (10) tick();
        check("dis_busy", busy, 1);
        end_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        check("dis_rx_start", rx_start, 0);
        check("dis_m_valid", m_valid, 1);
        tick();
        check("dis_sb_empty", sb_q.size(), 0);
        enable = 1'b1;
        tick();
        check("rearm", rx_start, 1);

        // Asynchronous reset mid-frame
        start_frame();
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("arst_rx_start", rx_start, 0);
        check("arst_busy", busy, 0);
        check("arst_rx_length", rx_length, 8);
        check("arst_rx_stop2", rx_stop2, 0);
        check("arst_m_valid", m_valid, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("final_sb_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the oversampling UART receiver. Arms the receiver, holds its frame configuration stable across a frame, and captures each received byte with an error tag into a small FIFO behind a valid/ready interface. Runs on the same 16x-baud clock as the receiver and sits between it and the host/bus logic.

## Interface
- FIFO_DEPTH, 4: receive FIFO entries; power of two, ≥2
- ERR_CNT_W, 8: width of the saturating error counter
- clk  in  1  16x-oversample clock, shared with the receiver
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  level; 1 = keep receiver armed
- cfg_wr  in  1  one-cycle config write strobe
- cfg_length  in  4  data bits, legal 5..8
- cfg_parity_en, cfg_parity_type, cfg_stop2  in  1 each  parity enable, 1=odd/0=even, two stop bits
- cfg_err  out  1  one-cycle pulse: illegal cfg_length, write ignored
- rx_line  in  1  serial line, same signal the receiver samples
- rx_start  out  1  receiver arm
- rx_length  out  4, rx_parity_en / rx_parity_type / rx_stop2  out  1 each  active config to receiver
- rx_data  in  8  receiver byte output
- rx_done  in  1  receiver one-cycle frame-complete
- rx_error  in  1  receiver error level
- m_data  out  8, m_err  out  1  FIFO head byte and its error tag
- m_valid  out  1, m_ready  in  1  output handshake
- overrun  out  1  sticky: byte dropped on full FIFO
- err_count  out  ERR_CNT_W  saturating count of errored/dropped/timed-out frames
- err_clr  in  1  clears err_count and overrun
- busy  out  1  1 while in FRAME
- timeout  out  1  one-cycle pulse on frame timeout

## Operation
- FSM: OFF, ARMED, FRAME.
- OFF: rx_start=0; enable=1 -> ARMED.
- ARMED: rx_start=1; enable=0 -> OFF; rx_line=0 -> FRAME, frame counter=0, frame error flag=0.
- FRAME: rx_start=1, busy=1; frame error flag |= rx_error every cycle; counter increments.
- rx_done=1 in ARMED or FRAME: capture {frame_err|rx_error, rx_data}; next state ARMED if enable else OFF. enable=0 mid-frame never aborts the frame.
- Capture: pushed if FIFO not full, or full with a pop in the same cycle. Otherwise the byte is dropped, overrun=1, err_count+1.
- Errored capture (tag=1): err_count+1. Dropped and errored in the same frame counts once.
- Config: cfg_wr with cfg_length outside 5..8 -> cfg_err pulse, no change. Legal write in OFF/ARMED applies next cycle. In FRAME it is held pending (last write wins) and applied on the cycle that leaves FRAME.
- err_count saturates at 2^ERR_CNT_W-1. err_clr with an increment in the same cycle -> err_count=1.
- FIFO: m_valid = !empty; pop on m_valid && m_ready; m_data/m_err show the head entry.

## Timing
- Reset: state OFF, rx_start 0, rx_length 8, rx_parity_en 0, rx_parity_type 0, rx_stop2 0, m_valid 0, m_data 0, m_err 0, overrun 0, err_count 0, busy 0, timeout 0, cfg_err 0, FIFO empty, no pending config.
- All outputs registered except m_data/m_err/m_valid (FIFO head, registered storage).
- rx_line low sampled in ARMED -> busy=1 next cycle.
- rx_done at cycle N -> m_valid=1 at N+1 (empty FIFO); state ARMED at N+1.
- Nominal rx_done arrives 16*(2+len+parity_en+stop2)+1 cycles after FRAME entry.
- cfg_err: pulses the cycle after cfg_wr.

## Configuration
- UART_RX_CTRL_TIMEOUT_EN defined: FRAME counter compared to T = 16*(3+rx_length+rx_parity_en+rx_stop2). Reaching T with no rx_done -> timeout pulse, err_count+1, nothing pushed, -> ARMED/OFF per enable, pending config applied. Recovers false starts.
- Not defined: no counter; FRAME waits indefinitely for rx_done; timeout tied 0.

## Test plan
- Reset, enable=1, 8N1 frame 0xA5 -> rx_start=1; m_data=0xA5, m_err=0, m_valid=1 the cycle after rx_done; err_count=0.
- cfg 7E1 in ARMED; frame with bad parity -> m_err=1, err_count=1. cfg_length=4 -> cfg_err pulse, rx_length unchanged.
- m_ready=0; send FIFO_DEPTH+1 frames -> first 4 bytes held in order; 5th dropped; overrun=1, err_count=1. err_clr -> both 0.
- cfg_wr (5 bits, stop2) mid-frame -> rx_length stays 8 until the FRAME exit cycle, then 5; next frame decoded as 5 bits.
- TIMEOUT_EN: 4-cycle low glitch on rx_line -> timeout pulse at cycle T=176 (8N1), err_count=1, state ARMED, m_valid=0.
- enable=0 mid-frame -> frame completes and is pushed, then rx_start=0; rst_n low mid-frame -> all outputs at reset values immediately.
